mem_client_port: RTL and testbench
==================================

Name: mem_client_port

Overview:
- Device-side initiator for one slot of the three-way memory arbiter.
- Takes a simple client request (single write, or read burst of 1..MAX_BURST words) and drives that slot's inputs: mem_en, burst_en, mem_addr, mem_di, bank_select and mem_we.
- Counts the slot's do_ack pulses and returns aligned read data.
- Instantiated once per bus master: instruction fetch, load/store, debug.

Parameters:
- ADDR_W, 10, word-address width of the arbiter slot.
- DATA_W, 32, data width.
- LEN_W, 4, width of the burst length field; MAX_BURST = 2**LEN_W - 1.
- ADDR_STRIDE, 4, address increment per acked beat.
- DATA_LAT, 1, cycles from a sampled do_ack to valid mem_do (1..3).
- TIMEOUT, 255, cycles mem_en may wait without an ack before the request is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  client request strobe
- req_ready  out  1  port idle; request accepted when req_valid&req_ready
- req_we  in  1  1 = write (single beat), 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  beats for reads; ignored for writes (treated as 1)
- req_wdata  in  DATA_W  write data
- req_bank  in  4  byte-lane/bank select
- rd_valid  out  1  read beat valid
- rd_data  out  DATA_W  read beat
- rd_last  out  1  final beat of the burst
- done  out  1  one-cycle pulse at transaction completion
- err  out  1  one-cycle pulse with done on timeout
- mem_en  out  1  to arbiter slot
- burst_en  out  1  to arbiter slot
- mem_addr  out  ADDR_W  to arbiter slot
- mem_di  out  DATA_W  to arbiter slot
- bank_select  out  4  to arbiter slot
- mem_we  out  1  to arbiter slot
- do_ack  in  1  this slot's ack bit from the arbiter
- mem_do  in  DATA_W  shared RAM read data

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - 0: all outputs except req_ready, including mem_addr, mem_di, bank_select, mem_we, burst_en, rd_*, done, err.
  - 1: req_ready.
  - State is IDLE.
- States: IDLE, REQ, DRAIN.
- IDLE:
  - req_ready=1.
  - On accept, register addr, wdata, bank and we. Register len: 0 is treated as 1; writes force 1.
  - Load beats_left=len and beats_out=len. Clear the wait counter. Go to REQ the next cycle.
- REQ:
  - mem_en=1. mem_we=we. burst_en = !we && beats_left>1.
  - Each cycle do_ack=1:
    - Decrement beats_left.
    - Advance mem_addr by ADDR_STRIDE. Width wraps modulo 2**ADDR_W, no carry out.
    - For reads, push a marker into the DATA_LAT alignment pipe.
    - Clear the wait counter.
  - When the ack consumes the last beat:
    - Drop mem_en and burst_en the next cycle.
    - Write: go to IDLE and pulse done in that same next cycle.
    - Read: go to DRAIN.
  - do_ack=0: increment the wait counter. If it reaches TIMEOUT, drop mem_en, pulse done+err, flush the pipe and go to IDLE. Acks arriving after that are ignored.
- Re-arbitration: mem_en stays high across a burst. When another slot is granted mid-burst, the acks simply stop. The port holds mem_addr at the next unacked beat and resumes counting when the acks return. No beat is duplicated or lost.
- DRAIN:
  - Wait for the pipe to emit all outstanding markers.
  - Each emitted marker gives rd_valid=1 and rd_data=mem_do sampled that cycle.
  - rd_last=1 when beats_out reaches 1.
  - After the last beat: done pulse the next cycle, then IDLE.
- Read beats:
  - Emitted exactly DATA_LAT cycles after their ack; at most one per cycle; in ack order.
  - rd_valid may also assert in REQ for earlier beats.
- A do_ack in IDLE or DRAIN (a spurious or late ack) is ignored and does not change any counter.
- req_valid during a busy state is not accepted. Requests are never queued.
- A reset mid-transaction drops mem_en immediately (asynchronously) and loses all outstanding beats. No done pulse is generated.

Decomposition:
- Shared package mem_client_pkg:
  - state encodings IDLE/REQ/DRAIN;
  - ADDR_STRIDE default;
  - slot indices DEVICE_1=0, DEVICE_2=1, DEVICE_3=2 and NO_ONE=3'b111, shared with the arbiter.
- Sub-module mem_rd_align: DATA_LAT-deep shift register of {valid, last} markers with async active-low reset and a flush input. It produces the rd_valid/rd_last timing. The top level captures mem_do.

Test Plan:
- Single write: addr=0x010, wdata=0xDEADBEEF, ack on the 2nd REQ cycle -> mem_en high for 2 cycles with mem_we=1, burst_en=0, mem_di=0xDEADBEEF; done pulses 1 cycle after the ack; err=0.
- Read burst: len=4 from 0x020 with acks on 4 consecutive cycles -> mem_addr steps 0x020, 0x024, 0x028, 0x02C; burst_en drops with the last ack; 4 rd_valid beats, each DATA_LAT after its ack, rd_last on the 4th; done after that.
- Preempted burst: len=3, ack, two idle cycles (another slot granted), then two acks -> mem_addr holds at 0x024 during the gap; exactly 3 beats returned in order.
- Timeout: TIMEOUT=8, read with no acks -> mem_en deasserts after 8 cycles; done=err=1 for one cycle; a later do_ack is ignored and req_ready stays 1.
- Wrap: read len=2 at 0x3FC -> second beat addressed at 0x000; no X on mem_addr.
- Reset mid-burst: assert reset after the 1st of 4 acks -> mem_en, rd_valid and done go 0 immediately; after release req_ready=1 and the next request starts clean.

Source files
------------

// File: rtl/mem_client_pkg.sv
// Shared types and constants for the memory-arbiter client ports.
package mem_client_pkg;

   // Client port sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Default word-address increment per acked beat
   localparam int ADDR_STRIDE_DEF = 4;

   // Arbiter slot indices, shared with the arbiter
   localparam logic [2:0] DEVICE_1 = 3'd0;
   localparam logic [2:0] DEVICE_2 = 3'd1;
   localparam logic [2:0] DEVICE_3 = 3'd2;
   localparam logic [2:0] NO_ONE   = 3'b111;

endpackage

// File: rtl/mem_rd_align.sv
// Read-beat alignment pipe: delays {valid, last} markers by LAT cycles so the
// emitted marker lines up with the cycle in which mem_do carries that beat.
module mem_rd_align #(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush_i,
   input  logic push_valid_i,
   input  logic push_last_i,
   output logic out_valid_o,
   output logic out_last_o
);

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] lst_q;

   // Shift markers one stage per cycle; flush drops everything in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= {LAT{1'b0}};
         lst_q <= {LAT{1'b0}};
      end else if (flush_i) begin
         vld_q <= {LAT{1'b0}};
         lst_q <= {LAT{1'b0}};
      end else begin
         vld_q[0] <= push_valid_i;
         lst_q[0] <= push_valid_i & push_last_i;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            lst_q[i] <= lst_q[i-1];
         end
      end
   end

   assign out_valid_o = vld_q[LAT-1];
   assign out_last_o  = lst_q[LAT-1];

endmodule

// File: rtl/mem_client_port.sv
// Device-side initiator for one slot of the three-way memory arbiter.
// Accepts a single write or a read burst, drives the slot request lines,
// counts this slot's acks and returns read beats aligned to mem_do.
module mem_client_port
   import mem_client_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 4,
   parameter int ADDR_STRIDE = ADDR_STRIDE_DEF,
   parameter int DATA_LAT    = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [3:0]        req_bank,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              done,
   output logic              err,
   output logic              mem_en,
   output logic              burst_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_di,
   output logic [3:0]        bank_select,
   output logic              mem_we,
   input  logic              do_ack,
   input  logic [DATA_W-1:0] mem_do
);

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [LEN_W-1:0]  ONE_BEAT  = LEN_W'(1);
   localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(ADDR_STRIDE);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [3:0]          bank_q, bank_d;
   logic                we_q, we_d;
   logic [LEN_W-1:0]    beats_left_q, beats_left_d;
   logic [LEN_W-1:0]    beats_out_q, beats_out_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                push_s;
   logic                push_last_s;
   logic                flush_s;
   logic                emit_s;
   logic                emit_last_s;

   // Writes are always one beat; a zero-length read still moves one word
   function automatic logic [LEN_W-1:0] eff_len(input logic we, input logic [LEN_W-1:0] len);
      if (we) begin
         return ONE_BEAT;
      end else if (len == {LEN_W{1'b0}}) begin
         return ONE_BEAT;
      end else begin
         return len;
      end
   endfunction

   mem_rd_align #(
      .LAT (DATA_LAT)
   ) u_align (
      .clk          (clk),
      .rst_n        (reset),
      .flush_i      (flush_s),
      .push_valid_i (push_s),
      .push_last_i  (push_last_s),
      .out_valid_o  (emit_s),
      .out_last_o   (emit_last_s)
   );

   // Next-state, beat bookkeeping, ack-wait timeout and completion pulses
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      bank_d       = bank_q;
      we_d         = we_q;
      beats_left_d = beats_left_q;
      wait_d       = wait_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      push_s       = 1'b0;
      push_last_s  = 1'b0;
      flush_s      = 1'b0;

      // Earlier read beats may come out while later ones are still being requested
      if (emit_s) begin
         beats_out_d = beats_out_q - ONE_BEAT;
      end else begin
         beats_out_d = beats_out_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d       = req_addr;
               wdata_d      = req_wdata;
               bank_d       = req_bank;
               we_d         = req_we;
               beats_left_d = eff_len(req_we, req_len);
               beats_out_d  = eff_len(req_we, req_len);
               wait_d       = {WAIT_W{1'b0}};
               state_d      = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (do_ack) begin
               // Address only moves on an ack, so a preempted burst resumes in place
               beats_left_d = beats_left_q - ONE_BEAT;
               addr_d       = addr_q + STRIDE;
               wait_d       = {WAIT_W{1'b0}};
               push_s       = !we_q;
               push_last_s  = !we_q && (beats_left_q == ONE_BEAT);
               if (beats_left_q == ONE_BEAT) begin
                  if (we_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_DRAIN;
                  end
               end else begin
                  state_d = ST_REQ;
               end
            end else if (wait_q == WAIT_LAST) begin
               // Abandon: beats already in the alignment pipe are discarded
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               flush_s = 1'b1;
               wait_d  = {WAIT_W{1'b0}};
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (emit_s && (beats_out_q == ONE_BEAT)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and transaction registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= {ADDR_W{1'b0}};
         wdata_q      <= {DATA_W{1'b0}};
         bank_q       <= 4'h0;
         we_q         <= 1'b0;
         beats_left_q <= {LEN_W{1'b0}};
         beats_out_q  <= {LEN_W{1'b0}};
         wait_q       <= {WAIT_W{1'b0}};
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         bank_q       <= bank_d;
         we_q         <= we_d;
         beats_left_q <= beats_left_d;
         beats_out_q  <= beats_out_d;
         wait_q       <= wait_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Slot request lines decode straight from registers so reset drops them at once
   assign req_ready   = (state_q == ST_IDLE);
   assign mem_en      = (state_q == ST_REQ);
   assign mem_we      = mem_en & we_q;
   assign burst_en    = mem_en & !we_q & (beats_left_q > ONE_BEAT);
   assign mem_addr    = addr_q;
   assign mem_di      = wdata_q;
   assign bank_select = bank_q;
   assign done        = done_q;
   assign err         = err_q;

   // mem_do is valid exactly in the cycle the pipe emits its marker
   assign rd_valid    = emit_s;
   assign rd_last     = emit_last_s;
   assign rd_data     = emit_s ? mem_do : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_client_port.sv
// Self-checking bench for mem_client_port: transaction-level reference model
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_mem_client_port;

   localparam int DATA_LAT    = 2;
   localparam int TIMEOUT     = 8;
   localparam int ADDR_STRIDE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [9:0]  req_addr;
   logic [3:0]  req_len;
   logic [31:0] req_wdata;
   logic [3:0]  req_bank;
   logic        rd_valid, rd_last, done, err;
   logic [31:0] rd_data;
   logic        mem_en, burst_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_di;
   logic [3:0]  bank_select;
   logic        do_ack;
   logic [31:0] mem_do;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int rd_cnt  = 0;

   mem_client_port #(
      .ADDR_W(10), .DATA_W(32), .LEN_W(4), .ADDR_STRIDE(ADDR_STRIDE),
      .DATA_LAT(DATA_LAT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_bank(req_bank),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .done(done), .err(err),
      .mem_en(mem_en), .burst_en(burst_en), .mem_addr(mem_addr), .mem_di(mem_di),
      .bank_select(bank_select), .mem_we(mem_we),
      .do_ack(do_ack), .mem_do(mem_do)
   );

   always #5 clk = ~clk;

   // Contents of the shared RAM as seen by this slot
   function automatic logic [31:0] ram_f(input logic [9:0] a);
      return 32'hD00D_0000 | {22'd0, a};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!seen) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            @(posedge clk);
            #1;
         end
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   // Environment RAM: read data appears DATA_LAT cycles after an accepted read ack
   logic [31:0]         ram_pipe [DATA_LAT];
   logic [DATA_LAT-1:0] ram_vld = '0;
   always @(posedge clk) begin
      ram_vld[0]  <= do_ack && mem_en && !mem_we;
      ram_pipe[0] <= ram_f(mem_addr);
      for (int i = 1; i < DATA_LAT; i++) begin
         ram_vld[i]  <= ram_vld[i-1];
         ram_pipe[i] <= ram_pipe[i-1];
      end
   end
   assign mem_do = ram_vld[DATA_LAT-1] ? ram_pipe[DATA_LAT-1] : 32'hBAD0_0000;

   always @(negedge clk) begin
      if (reset === 1'b1 && rd_valid === 1'b1) rd_cnt++;
   end

   // Reference model: phase 0 idle, 1 requesting, 2 draining
   int          m_phase, m_start, m_acked, m_n, m_wait, m_done_cyc;
   bit          m_we, m_err;
   logic [31:0] m_wdata;
   logic [3:0]  m_bank;
   int          q_due[$];
   logic [31:0] q_data[$];
   bit          q_last[$];
   bit          exp_en;

   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         m_phase = 0; m_start = 0; m_acked = 0; m_n = 0; m_wait = 0;
         m_done_cyc = -1; m_we = 1'b0; m_err = 1'b0;
         m_wdata = 32'd0; m_bank = 4'd0;
         q_due.delete(); q_data.delete(); q_last.delete();
      end
      exp_en = (m_phase == 1);
      chk("req_ready", 32'(req_ready), 32'(m_phase == 0));
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("mem_we", 32'(mem_we), 32'(exp_en && m_we));
      chk("burst_en", 32'(burst_en), 32'(exp_en && !m_we && (m_n - m_acked > 1)));
      chk("mem_addr", 32'(mem_addr), 32'((m_start + ADDR_STRIDE * m_acked) % 1024));
      chk("mem_di", mem_di, m_wdata);
      chk("bank_select", 32'(bank_select), 32'(m_bank));
      chk("done", 32'(done), 32'(cyc == m_done_cyc));
      chk("err", 32'(err), 32'((cyc == m_done_cyc) && m_err));
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         chk("rd_valid", 32'(rd_valid), 32'd1);
         chk("rd_data", rd_data, q_data[0]);
         chk("rd_last", 32'(rd_last), 32'(q_last[0]));
         void'(q_due.pop_front());
         void'(q_data.pop_front());
         void'(q_last.pop_front());
      end else begin
         chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      end

      if (reset === 1'b1) begin
         case (m_phase)
            0: if (req_valid) begin
                  m_phase = 1; m_start = int'(req_addr); m_we = req_we;
                  m_n = req_we ? 1 : ((req_len == 4'd0) ? 1 : int'(req_len));
                  m_acked = 0; m_wait = 0; m_wdata = req_wdata; m_bank = req_bank;
               end
            1: if (do_ack) begin
                  if (!m_we) begin
                     q_due.push_back(cyc + DATA_LAT);
                     q_data.push_back(ram_f(10'((m_start + ADDR_STRIDE * m_acked) % 1024)));
                     q_last.push_back(m_acked + 1 == m_n);
                  end
                  m_acked++;
                  m_wait = 0;
                  if (m_acked == m_n) begin
                     m_err = 1'b0;
                     if (m_we) begin
                        m_phase = 0; m_done_cyc = cyc + 1;
                     end else begin
                        m_phase = 2; m_done_cyc = cyc + DATA_LAT + 1;
                     end
                  end
               end else begin
                  m_wait++;
                  if (m_wait == TIMEOUT) begin
                     m_phase = 0; m_done_cyc = cyc + 1; m_err = 1'b1;
                     q_due.delete(); q_data.delete(); q_last.delete();
                  end
               end
            2: if (cyc + 1 == m_done_cyc) m_phase = 0;
            default: m_phase = 0;
         endcase
      end
      cyc++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  base;
      int  cnt;
      bit  seen;
      bit  ack_pat [5];

      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'd0;
      req_len = 4'd0; req_wdata = 32'd0; req_bank = 4'd0; do_ack = 1'b0;
      repeat (3) next_cycle();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();

      // Single write, ack on the second REQ cycle
      req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h010; req_wdata = 32'hDEADBEEF;
      req_bank = 4'h3; req_len = 4'd5;
      next_cycle();
      req_valid = 1'b0; do_ack = 1'b0;
      @(negedge clk);
      chk("wr_en_c1", 32'(mem_en), 32'd1);
      next_cycle();
      do_ack = 1'b1;
      @(negedge clk);
      chk("wr_en_c2", 32'(mem_en), 32'd1);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_burst", 32'(burst_en), 32'd0);
      chk("wr_di", mem_di, 32'hDEADBEEF);
      next_cycle();
      do_ack = 1'b0;
      @(negedge clk);
      chk("wr_done", 32'(done), 32'd1);
      chk("wr_err", 32'(err), 32'd0);
      chk("wr_en_off", 32'(mem_en), 32'd0);
      next_cycle();

      // Read burst of 4 with back-to-back acks, plus a spurious ack in DRAIN
      base = rd_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h020; req_len = 4'd4;
      req_wdata = 32'h1234_5678; req_bank = 4'hA;
      next_cycle();
      req_valid = 1'b0; do_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rb_addr", 32'(mem_addr), 32'h020 + 32'(4 * i));
         chk("rb_burst", 32'(burst_en), 32'(i < 3));
         next_cycle();
      end
      next_cycle();
      do_ack = 1'b0;
      wait_done("rb_done");
      chk("rb_beats", 32'(rd_cnt - base), 32'd4);

      // Preempted burst of 3: ack, two-cycle gap, two acks
      base = rd_cnt;
      ack_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h020; req_len = 4'd3;
      next_cycle();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_ack = ack_pat[i];
         if (i == 1 || i == 2) begin
            @(negedge clk);
            chk("pre_hold_addr", 32'(mem_addr), 32'h024);
         end
         next_cycle();
      end
      do_ack = 1'b0;
      wait_done("pre_done");
      chk("pre_beats", 32'(rd_cnt - base), 32'd3);

      // Timeout with no acks
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h100; req_len = 4'd2;
      next_cycle();
      req_valid = 1'b0;
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!seen) begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
               cnt++;
               next_cycle();
            end else begin
               seen = 1'b1;
            end
         end
      end
      chk("to_en_cycles", 32'(cnt), 32'd8);
      chk("to_done", 32'(done), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      next_cycle();
      do_ack = 1'b1;
      next_cycle();
      do_ack = 1'b0;
      @(negedge clk);
      chk("to_late_ready", 32'(req_ready), 32'd1);
      chk("to_late_en", 32'(mem_en), 32'd0);
      next_cycle();

      // Address wrap at the top of the slot
      base = rd_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h3FC; req_len = 4'd2;
      next_cycle();
      req_valid = 1'b0; do_ack = 1'b1;
      @(negedge clk);
      chk("wrap_addr0", 32'(mem_addr), 32'h3FC);
      next_cycle();
      @(negedge clk);
      chk("wrap_addr1", 32'(mem_addr), 32'h000);
      next_cycle();
      do_ack = 1'b0;
      wait_done("wrap_done");
      chk("wrap_beats", 32'(rd_cnt - base), 32'd2);

      // Reset in the middle of a 4-beat read
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h040; req_len = 4'd4;
      next_cycle();
      req_valid = 1'b0; do_ack = 1'b1;
      next_cycle();
      do_ack = 1'b0;
      next_cycle();
      #1;
      chk("mr_rdv_before", 32'(rd_valid), 32'd1);
      chk("mr_en_before", 32'(mem_en), 32'd1);
      reset = 1'b0;
      #1;
      chk("mr_en_async", 32'(mem_en), 32'd0);
      chk("mr_rdv_async", 32'(rd_valid), 32'd0);
      chk("mr_done_async", 32'(done), 32'd0);
      next_cycle();
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("mr_ready_after", 32'(req_ready), 32'd1);
      next_cycle();

      // Clean restart: zero-length read behaves as a single beat
      base = rd_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h200; req_len = 4'd0;
      next_cycle();
      req_valid = 1'b0; do_ack = 1'b1;
      @(negedge clk);
      chk("z_burst", 32'(burst_en), 32'd0);
      next_cycle();
      do_ack = 1'b0;
      wait_done("z_done");
      chk("z_beats", 32'(rd_cnt - base), 32'd1);

      repeat (2) next_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
